// File: rtl/pwm_duty_decoder.sv
// Recovers the 8-bit duty and the period of an asynchronous PWM line, with timeout detection.
// Optional PWM_DEC_GLITCH_FILTER_EN: requires 2 stable cycles before the measured level changes.
module pwm_duty_decoder #(
    parameter  int PERIOD_LOG2 = 8,
    parameter  int SYNC_STAGES = 2,
    localparam int CNT_W       = PERIOD_LOG2 + 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [7:0]       duty_out,
    output logic [CNT_W-1:0] period_out,
    output logic             duty_valid,
    output logic             period_err,
    output logic             stalled
);

    localparam logic [CNT_W-1:0] NOM_PER = CNT_W'(2 ** PERIOD_LOG2);
    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(2 ** (PERIOD_LOG2 + 1));
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, STALL} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_s, pwm_d;
    logic                   lvl, lvl_prev;
    logic                   rise_q, fall_q, lvl_q;
    state_t                 state;
    logic [CNT_W-1:0]       per_cnt, high_cnt, duty_shift;
    logic [7:0]             duty_sat;

    always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end

    assign pwm_s = sync_q[SYNC_STAGES-1];

`ifdef PWM_DEC_GLITCH_FILTER_EN
    logic filt_q;

    // The filtered level follows pwm_s only once pwm_s and its delayed copy agree.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_d  <= 1'b0;
            filt_q <= 1'b0;
        end else begin
            pwm_d  <= pwm_s;
            filt_q <= lvl;
        end
    end

    assign lvl      = (pwm_s == pwm_d) ? pwm_s : filt_q;
    assign lvl_prev = filt_q;
`else
    always_ff @(posedge clk) begin
        if (reset) pwm_d <= 1'b0;
        else       pwm_d <= pwm_s;
    end

    assign lvl      = pwm_s;
    assign lvl_prev = pwm_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            lvl_q  <= 1'b0;
        end else begin
            rise_q <= lvl & ~lvl_prev;
            fall_q <= ~lvl & lvl_prev;
            lvl_q  <= lvl;
        end
    end

    assign duty_shift = high_cnt >> (PERIOD_LOG2 - 8);
    assign duty_sat   = (duty_shift > CNT_W'(255)) ? 8'hFF : duty_shift[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            per_cnt    <= '0;
            high_cnt   <= '0;
            duty_out   <= '0;
            period_out <= '0;
            duty_valid <= 1'b0;
            period_err <= 1'b0;
            stalled    <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            case (state)
                IDLE, HIGH, LOW: begin
                    if (per_cnt == TMO_CNT) begin
                        state      <= STALL;
                        duty_out   <= lvl_q ? 8'hFF : 8'h00;
                        period_out <= '0;
                        period_err <= 1'b0;
                        stalled    <= 1'b1;
                        duty_valid <= 1'b1;
                    end else if (rise_q) begin
                        // Only a rise that closes a full observed period is reported.
                        if (state == LOW) begin
                            duty_out   <= duty_sat;
                            period_out <= per_cnt;
                            period_err <= (per_cnt != NOM_PER);
                            stalled    <= 1'b0;
                            duty_valid <= 1'b1;
                        end
                        state    <= HIGH;
                        high_cnt <= ONE;
                        per_cnt  <= ONE;
                    end else begin
                        per_cnt <= per_cnt + ONE;
                        if (state == HIGH) begin
                            if (fall_q)     state    <= LOW;
                            else if (lvl_q) high_cnt <= high_cnt + ONE;
                        end
                    end
                end
                STALL: begin
                    if (rise_q) begin
                        state    <= HIGH;
                        high_cnt <= ONE;
                        per_cnt  <= ONE;
                    end else if (fall_q) begin
                        state   <= IDLE;
                        per_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Self-checking bench for pwm_duty_decoder: vector table, scoreboard over random PWM, directed corners.
module tb_pwm_duty_decoder;

    localparam int PL = 8;
    localparam int SS = 2;
    localparam int CW = PL + 2;
`ifdef PWM_DEC_GLITCH_FILTER_EN
    localparam int LAT = SS + 2;
`else
    localparam int LAT = SS + 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pwm_in = 1'b0;
    logic [7:0]    duty_out;
    logic [CW-1:0] period_out;
    logic          duty_valid, period_err, stalled;

    pwm_duty_decoder #(.PERIOD_LOG2(PL), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .reset     (reset),
        .pwm_in    (pwm_in),
        .duty_out  (duty_out),
        .period_out(period_out),
        .duty_valid(duty_valid),
        .period_err(period_err),
        .stalled   (stalled)
    );

    always #5 clk = ~clk;

    typedef struct {
        int duty;
        int period;
        int err;
        int stl;
    } strobe_t;

    typedef struct {
        int h;
        int l;
        int e_duty;
        int e_per;
        int e_err;
    } vec_t;

    int      n_chk = 0;
    int      n_fail = 0;
    int      cyc = 0;
    int      strobe_cnt = 0;
    bit      sb_on = 1'b0;
    strobe_t last;
    strobe_t exp_s;
    strobe_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: records every strobe; in scoreboard mode compares against the expected queue.
    always @(negedge clk) begin
        if (duty_valid) begin
            strobe_cnt++;
            last.duty   = int'(duty_out);
            last.period = int'(period_out);
            last.err    = int'(period_err);
            last.stl    = int'(stalled);
            if (sb_on) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_extra: unexpected strobe duty=%0d period=%0d err=%0d stalled=%0d",
                             last.duty, last.period, last.err, last.stl);
                end else begin
                    exp_s = exp_q.pop_front();
                    if (exp_s.duty != last.duty || exp_s.period != last.period ||
                        exp_s.err != last.err || exp_s.stl != last.stl) begin
                        n_fail++;
                        $display("FAIL sb_strobe: got duty=%0d period=%0d err=%0d stalled=%0d expected duty=%0d period=%0d err=%0d stalled=%0d",
                                 last.duty, last.period, last.err, last.stl,
                                 exp_s.duty, exp_s.period, exp_s.err, exp_s.stl);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_seg(input int h, input int l);
        pwm_in = 1'b1;
        repeat (h) tick();
        pwm_in = 1'b0;
        repeat (l) tick();
    endtask

    task automatic do_reset();
        pwm_in = 1'b0;
        reset  = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_duty"},   int'(duty_out),   0);
        check({tag, "_period"}, int'(period_out), 0);
        check({tag, "_valid"},  int'(duty_valid), 0);
        check({tag, "_err"},    int'(period_err), 0);
        check({tag, "_stall"},  int'(stalled),    0);
    endtask

    // Reference: a full period of h high and l low cycles reports these values.
    function automatic strobe_t seg_exp(input int h, input int l);
        strobe_t s;
        int      d;
        d        = h >> (PL - 8);
        s.duty   = (d > 255) ? 255 : d;
        s.period = h + l;
        s.err    = ((h + l) != (1 << PL)) ? 1 : 0;
        s.stl    = 0;
        return s;
    endfunction

    function automatic strobe_t mk(input int d, input int p, input int e, input int s);
        strobe_t r;
        r.duty = d; r.period = p; r.err = e; r.stl = s;
        return r;
    endfunction

    initial begin
        vec_t vecs[7];
        int   seg_h[$];
        int   seg_l[$];
        int   e0, lat, h, l;

        vecs[0] = '{64,  192, 64,  256, 0};
        vecs[1] = '{50,  150, 50,  200, 1};
        vecs[2] = '{128, 128, 128, 256, 0};
        vecs[3] = '{2,   254, 2,   256, 0};
        vecs[4] = '{254, 2,   254, 256, 0};
        vecs[5] = '{300, 100, 255, 400, 1};
        vecs[6] = '{200, 311, 200, 511, 1};

        do_reset();
        check_zero("reset");

        // Table: three full periods plus a closing rise give three strobes.
        foreach (vecs[i]) begin
            do_reset();
            repeat (3) tick();
            strobe_cnt = 0;
            repeat (3) drive_seg(vecs[i].h, vecs[i].l);
            pwm_in = 1'b1;
            repeat (LAT + 3) tick();
            check($sformatf("vec%0d_count", i),  strobe_cnt,      3);
            check($sformatf("vec%0d_duty", i),   int'(duty_out),   vecs[i].e_duty);
            check($sformatf("vec%0d_period", i), int'(period_out), vecs[i].e_per);
            check($sformatf("vec%0d_err", i),    int'(period_err), vecs[i].e_err);
            check($sformatf("vec%0d_stall", i),  int'(stalled),    0);
        end

        // Latency from the sampling edge of the closing rise to the strobe.
        do_reset();
        repeat (3) tick();
        drive_seg(64, 192);
        pwm_in = 1'b1;
        @(posedge clk);
        #1;
        e0  = cyc;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (duty_valid) begin
                lat = cyc - e0;
                break;
            end
        end
        check("latency", lat, LAT);

        // Scoreboard: duty step 128 -> 192, then random periods below the timeout.
        do_reset();
        repeat (3) tick();
        repeat (3) begin seg_h.push_back(128); seg_l.push_back(128); end
        repeat (3) begin seg_h.push_back(192); seg_l.push_back(64);  end
        repeat (20) begin
            h = $urandom_range(400, 2);
            l = $urandom_range(511 - h, 2);
            seg_h.push_back(h);
            seg_l.push_back(l);
        end
        exp_q.delete();
        sb_on = 1'b1;
        foreach (seg_h[i]) begin
            if (i > 0) exp_q.push_back(seg_exp(seg_h[i-1], seg_l[i-1]));
            drive_seg(seg_h[i], seg_l[i]);
        end
        exp_q.push_back(seg_exp(seg_h[seg_h.size()-1], seg_l[seg_l.size()-1]));
        pwm_in = 1'b1;
        repeat (LAT + 3) tick();
        sb_on = 1'b0;
        check("sb_drain", exp_q.size(), 0);

        // One-cycle low glitch inside the high phase of a 64/256 wave.
        do_reset();
        repeat (3) tick();
        exp_q.delete();
        exp_q.push_back(mk(64, 256, 0, 0));
`ifdef PWM_DEC_GLITCH_FILTER_EN
        exp_q.push_back(mk(64, 256, 0, 0));
`else
        exp_q.push_back(mk(30, 31, 1, 0));
        exp_q.push_back(mk(33, 225, 1, 0));
`endif
        sb_on = 1'b1;
        drive_seg(64, 192);
        pwm_in = 1'b1; repeat (30) tick();
        pwm_in = 1'b0; tick();
        pwm_in = 1'b1; repeat (33) tick();
        pwm_in = 1'b0; repeat (192) tick();
        pwm_in = 1'b1;
        repeat (LAT + 3) tick();
        sb_on = 1'b0;
        check("glitch_drain", exp_q.size(), 0);

        // Stall high, stall low, then recovery.
        do_reset();
        repeat (3) tick();
        strobe_cnt = 0;
        drive_seg(64, 192);
        pwm_in = 1'b1;
        repeat (600) tick();
        check("stall_hi_count",  strobe_cnt,       2);
        check("stall_hi_duty",   int'(duty_out),   255);
        check("stall_hi_period", int'(period_out), 0);
        check("stall_hi_err",    int'(period_err), 0);
        check("stall_hi_flag",   int'(stalled),    1);
        pwm_in = 1'b0;
        repeat (600) tick();
        check("stall_lo_count", strobe_cnt,     3);
        check("stall_lo_duty",  int'(duty_out), 0);
        check("stall_lo_flag",  int'(stalled),  1);
        drive_seg(64, 192);
        check("resume_quiet", strobe_cnt,    3);
        check("resume_stall", int'(stalled), 1);
        pwm_in = 1'b1;
        repeat (LAT + 3) tick();
        check("resume_count",  strobe_cnt,  4);
        check("resume_flag",   last.stl,    0);
        check("resume_duty",   last.duty,   64);
        check("resume_period", last.period, 256);
        check("resume_err",    last.err,    0);

        // Reset in the middle of a high phase.
        do_reset();
        repeat (3) tick();
        drive_seg(64, 192);
        pwm_in = 1'b1;
        repeat (20) tick();
        check("pre_rst_period", int'(period_out), 256);
        reset = 1'b1;
        tick();
        check_zero("midrst");
        pwm_in = 1'b0;
        reset  = 1'b0;
        repeat (50) tick();
        strobe_cnt = 0;
        drive_seg(64, 192);
        check("rst_first_rise", strobe_cnt, 0);
        pwm_in = 1'b1;
        repeat (LAT + 3) tick();
        check("rst_second_rise", strobe_cnt,  1);
        check("rst_duty",        last.duty,   64);
        check("rst_period",      last.period, 256);
        pwm_in = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "timeout");
    end

endmodule
